pcie_link_monitor: RTL and testbench
====================================

# pcie_link_monitor

Consumes the four asynchronous link-status outputs of the PCIe hard-IP system (`ss_app_linkup`, `ss_app_dlup`, `ss_app_serr`, `ss_app_surprise_down_err`) and turns them into a qualified link state, saturating event counters and an acknowledged interrupt. It sits directly downstream of the PCIe system top, in the application clock domain. Management logic and the reset sequencer use it as the single source of truth for "link usable".

## Interface
- `SYNC_STAGES`, 2, synchronizer depth per status input (min 2).
- `STABLE_CYCLES`, 1024, cycles `dlup` and `linkup` must both hold before the link is declared up (min 1).
- `TRAIN_TIMEOUT`, 1048576, cycles allowed in TRAIN before flagging timeout.
- `CNT_W`, 16, event counter width.

- `clk` in 1: application clock; all logic is on this clock.
- `reset_n` in 1: asynchronous assert, active-low; deassertion is synchronized externally.
- `linkup_in` in 1: async; from `ss_app_linkup`.
- `dlup_in` in 1: async; from `ss_app_dlup`.
- `serr_in` in 1: async; from `ss_app_serr`.
- `surprise_down_in` in 1: async; from `ss_app_surprise_down_err`.
- `clear_stats` in 1: single-cycle pulse; zeroes counters and `train_timeout`.
- `irq_ack` in 1: single-cycle pulse; clears the cause bits set at that cycle.
- `link_state` out 2: DOWN=0, TRAIN=1, QUAL=2, UP=3.
- `link_up` out 1: high only in UP.
- `linkup_cnt` out CNT_W: QUAL→UP transitions.
- `surprise_down_cnt` out CNT_W: rising edges of synced surprise-down.
- `serr_cnt` out CNT_W: rising edges of synced serr.
- `train_timeout` out 1: sticky.
- `irq` out 1: OR of `irq_cause`.
- `irq_cause` out 3: bit0 link lost, bit1 serr, bit2 train timeout.

## Operation
- Each input passes through a `SYNC_STAGES` flop synchronizer. Edge detection compares the synced value against a one-cycle-delayed copy.
- FSM:
  - DOWN: synced `linkup` → TRAIN; clear the train timer.
  - TRAIN: `!linkup` → DOWN. `linkup && dlup` → QUAL; clear the stable counter. Otherwise increment the train timer. When the timer reaches `TRAIN_TIMEOUT-1`, set `train_timeout` and cause bit2 once; the FSM stays in TRAIN.
  - QUAL: `!linkup` → DOWN. `!dlup` → TRAIN. When the stable counter reaches `STABLE_CYCLES-1` → UP, and `linkup_cnt` increments.
  - UP: `!linkup` or `!dlup` → DOWN and set cause bit0.
- Counters saturate at all-ones and never wrap. Rising edge of serr increments `serr_cnt` and sets cause bit1.
- `clear_stats` coincident with an increment: clear wins, so the counter reads 0.
- `irq_ack` coincident with a new event: set wins, so the bit stays 1.
- `clear_stats` does not touch `irq_cause` or the FSM.
- Reset mid-operation: everything returns to reset values immediately. Synchronizer flops reset to 0.

## Timing
- Reset values:
  - `link_state`=DOWN, `link_up`=0.
  - All counters 0.
  - `train_timeout`=0, `irq`=0, `irq_cause`=0.
- Latency from input change to synced value: `SYNC_STAGES` cycles. Registered outputs (state, counters, cause) update 1 cycle after that.
- `link_up` rises exactly `STABLE_CYCLES` cycles after the FSM enters QUAL.
- `link_up` falls 1 cycle after the synced drop.
- `irq` is registered and follows `irq_cause` with 0 additional cycles (combinational OR of registered bits).

## Configuration
- `PCIE_LINK_MON_TIMESTAMP_EN` defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, which wraps.
  - Adds output `last_up_ts` out 32, loaded with that counter on every QUAL→UP transition. Reset value 0.
- Undefined: neither the counter nor the port exists. All other behaviour is identical.

## Structure
- `pcie_link_mon_pkg`:
  - `link_state_e` enum.
  - Cause bit index constants `CAUSE_DOWN`=0, `CAUSE_SERR`=1, `CAUSE_TMO`=2.
- Sub-module `pcie_sync_bit` (parameter `SYNC_STAGES`, async active-low reset), instantiated four times.

## Test plan
- Normal link-up: assert `linkup_in`, then `dlup_in` 10 cycles later, hold both, with `STABLE_CYCLES`=16.
  - `link_state` goes DOWN→TRAIN→QUAL→UP.
  - `link_up`=1 exactly 16 cycles after QUAL entry.
  - `linkup_cnt`=1; `irq`=0.
- Glitch during qualification: drop `dlup_in` for 3 cycles at QUAL cycle 8.
  - FSM returns to TRAIN; `link_up` stays 0.
  - Re-qualification takes a full 16 cycles; `linkup_cnt` unchanged until then.
- Link loss and acknowledge: from UP, deassert `linkup_in`.
  - State goes to DOWN and `irq_cause`=3'b001.
  - Pulse `irq_ack` → `irq`=0.
  - Repeat with a serr edge on the ack cycle → `irq_cause`=3'b010 remains.
- Training timeout: `TRAIN_TIMEOUT`=64, hold `linkup_in`=1 and `dlup_in`=0.
  - At TRAIN cycle 64, `train_timeout`=1 and cause bit2=1.
  - `clear_stats` → `train_timeout`=0; cause bit2 stays 1.
- Saturation and clear race, with `CNT_W`=4: apply 20 serr pulses.
  - `serr_cnt`=15.
  - `clear_stats` on the same cycle as a surprise-down edge → `surprise_down_cnt`=0.
- Async reset mid-QUAL: assert `reset_n`=0 for 1 cycle.
  - All outputs return to reset values in the same cycle.
  - With `PCIE_LINK_MON_TIMESTAMP_EN`, `last_up_ts` equals the cycle-counter value at the UP transition.

Source files
------------

// File: rtl/pcie_link_mon_pkg.sv
//------------------------------------------------------------------------------
// pcie_link_mon_pkg
// Shared types and constants for the PCIe link monitor: link state encoding
// and interrupt cause bit positions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pcie_link_mon_pkg;

  typedef enum logic [1:0] {
    ST_DOWN  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_QUAL  = 2'd2,
    ST_UP    = 2'd3
  } link_state_e;

  localparam int CAUSE_W    = 3;
  localparam int CAUSE_DOWN = 0;
  localparam int CAUSE_SERR = 1;
  localparam int CAUSE_TMO  = 2;

endpackage : pcie_link_mon_pkg

`default_nettype wire

// File: rtl/pcie_sync_bit.sv
//------------------------------------------------------------------------------
// pcie_sync_bit
// Multi-flop synchronizer for a single asynchronous status bit. The output
// reflects an input change after exactly SYNC_STAGES clock edges.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pcie_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift the raw input through the synchronizer chain; flops clear to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule : pcie_sync_bit

`default_nettype wire

// File: rtl/pcie_link_monitor.sv
//------------------------------------------------------------------------------
// pcie_link_monitor
// Qualifies the PCIe hard-IP link status into a DOWN/TRAIN/QUAL/UP state,
// keeps saturating event counters and raises an acknowledged interrupt.
// Optional feature macro: PCIE_LINK_MON_TIMESTAMP_EN adds a free-running
// cycle counter and the last_up_ts output.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pcie_link_monitor
  import pcie_link_mon_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int TRAIN_TIMEOUT = 1048576,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             linkup_in,
  input  logic             dlup_in,
  input  logic             serr_in,
  input  logic             surprise_down_in,
  input  logic             clear_stats,
  input  logic             irq_ack,
  output logic [1:0]       link_state,
  output logic             link_up,
  output logic [CNT_W-1:0] linkup_cnt,
  output logic [CNT_W-1:0] surprise_down_cnt,
  output logic [CNT_W-1:0] serr_cnt,
  output logic             train_timeout,
  output logic             irq,
`ifdef PCIE_LINK_MON_TIMESTAMP_EN
  output logic [31:0]      last_up_ts,
`endif
  output logic [2:0]       irq_cause
);

  // Train timer saturates one past the firing point so the timeout fires once.
  localparam int TMR_W = $clog2(TRAIN_TIMEOUT + 1);
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [TMR_W-1:0] c_tmr_fire = TMR_W'(TRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_tmr_sat  = TMR_W'(TRAIN_TIMEOUT);
  localparam logic [STB_W-1:0] c_stb_last = STB_W'(STABLE_CYCLES - 1);

  // Synchronized status bits: [0] linkup, [1] dlup, [2] serr, [3] surprise.
  logic [3:0] w_async;
  logic [3:0] w_synced;
  logic       w_linkup_s;
  logic       w_dlup_s;
  logic       w_serr_s;
  logic       w_sdn_s;

  logic r_serr_d;
  logic r_sdn_d;
  logic w_serr_rise;
  logic w_sdn_rise;

  link_state_e r_state;
  link_state_e w_state_nxt;
  logic [TMR_W-1:0] r_tmr;
  logic [STB_W-1:0] r_stb;
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_stb_clr;
  logic w_stb_inc;
  logic w_up_evt;
  logic w_lost_evt;
  logic w_tmo_evt;

  logic [CNT_W-1:0]   r_linkup_cnt;
  logic [CNT_W-1:0]   r_sdn_cnt;
  logic [CNT_W-1:0]   r_serr_cnt;
  logic               r_train_timeout;
  logic [CAUSE_W-1:0] r_cause;
  logic [CAUSE_W-1:0] w_cause_set;

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign w_async = {surprise_down_in, serr_in, dlup_in, linkup_in};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      pcie_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (w_async[gi]),
        .o_q     (w_synced[gi])
      );
    end
  endgenerate

  assign w_linkup_s = w_synced[0];
  assign w_dlup_s   = w_synced[1];
  assign w_serr_s   = w_synced[2];
  assign w_sdn_s    = w_synced[3];

  // One-cycle delayed copies of the synced event inputs for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_serr_d <= 1'b0;
      r_sdn_d  <= 1'b0;
    end else begin
      r_serr_d <= w_serr_s;
      r_sdn_d  <= w_sdn_s;
    end
  end

  assign w_serr_rise = w_serr_s & ~r_serr_d;
  assign w_sdn_rise  = w_sdn_s & ~r_sdn_d;

  // Link state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_DOWN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus timer controls and link events.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    w_tmr_inc   = 1'b0;
    w_stb_clr   = 1'b0;
    w_stb_inc   = 1'b0;
    w_up_evt    = 1'b0;
    w_lost_evt  = 1'b0;
    w_tmo_evt   = 1'b0;
    case (r_state)
      ST_DOWN: begin
        w_tmr_clr = 1'b1;
        if (w_linkup_s) begin
          w_state_nxt = ST_TRAIN;
        end
      end
      ST_TRAIN: begin
        if (!w_linkup_s) begin
          w_state_nxt = ST_DOWN;
        end else if (w_dlup_s) begin
          w_state_nxt = ST_QUAL;
          w_stb_clr   = 1'b1;
        end else begin
          w_tmr_inc = (r_tmr != c_tmr_sat);
          w_tmo_evt = (r_tmr == c_tmr_fire);
        end
      end
      ST_QUAL: begin
        if (!w_linkup_s) begin
          w_state_nxt = ST_DOWN;
        end else if (!w_dlup_s) begin
          w_state_nxt = ST_TRAIN;
        end else if (r_stb == c_stb_last) begin
          w_state_nxt = ST_UP;
          w_up_evt    = 1'b1;
        end else begin
          w_stb_inc = 1'b1;
        end
      end
      ST_UP: begin
        if (!w_linkup_s || !w_dlup_s) begin
          w_state_nxt = ST_DOWN;
          w_lost_evt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_DOWN;
      end
    endcase
  end

  // Train timer and stable counter; the timer stops at its saturation value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmr <= '0;
      r_stb <= '0;
    end else begin
      if (w_tmr_clr) begin
        r_tmr <= '0;
      end else if (w_tmr_inc) begin
        r_tmr <= r_tmr + TMR_W'(1);
      end
      if (w_stb_clr) begin
        r_stb <= '0;
      end else if (w_stb_inc) begin
        r_stb <= r_stb + STB_W'(1);
      end
    end
  end

  // Saturating event counters; clear_stats takes priority over an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_linkup_cnt <= '0;
      r_sdn_cnt    <= '0;
      r_serr_cnt   <= '0;
    end else if (clear_stats) begin
      r_linkup_cnt <= '0;
      r_sdn_cnt    <= '0;
      r_serr_cnt   <= '0;
    end else begin
      if (w_up_evt) begin
        r_linkup_cnt <= f_sat_inc(r_linkup_cnt);
      end
      if (w_sdn_rise) begin
        r_sdn_cnt <= f_sat_inc(r_sdn_cnt);
      end
      if (w_serr_rise) begin
        r_serr_cnt <= f_sat_inc(r_serr_cnt);
      end
    end
  end

  // Sticky timeout flag, cleared only by clear_stats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_train_timeout <= 1'b0;
    end else if (clear_stats) begin
      r_train_timeout <= 1'b0;
    end else if (w_tmo_evt) begin
      r_train_timeout <= 1'b1;
    end
  end

  // Gather this cycle's interrupt cause events.
  always_comb begin
    w_cause_set             = '0;
    w_cause_set[CAUSE_DOWN] = w_lost_evt;
    w_cause_set[CAUSE_SERR] = w_serr_rise;
    w_cause_set[CAUSE_TMO]  = w_tmo_evt;
  end

  // Cause bits: acknowledge clears, a new event in the same cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause <= '0;
    end else begin
      r_cause <= (irq_ack ? '0 : r_cause) | w_cause_set;
    end
  end

`ifdef PCIE_LINK_MON_TIMESTAMP_EN
  logic [31:0] r_cyc;
  logic [31:0] r_last_up_ts;

  // Free-running wrap-around cycle counter, captured on every link-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cyc        <= '0;
      r_last_up_ts <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      if (w_up_evt) begin
        r_last_up_ts <= r_cyc;
      end
    end
  end

  assign last_up_ts = r_last_up_ts;
`endif

  assign link_state        = r_state;
  assign link_up           = (r_state == ST_UP);
  assign linkup_cnt        = r_linkup_cnt;
  assign surprise_down_cnt = r_sdn_cnt;
  assign serr_cnt          = r_serr_cnt;
  assign train_timeout     = r_train_timeout;
  assign irq_cause         = r_cause;
  assign irq               = |r_cause;

endmodule : pcie_link_monitor

`default_nettype wire

// File: tb/tb_pcie_link_monitor.sv
//------------------------------------------------------------------------------
// tb_pcie_link_monitor
// Directed self-checking bench for pcie_link_monitor with small parameters
// (STABLE_CYCLES=16, TRAIN_TIMEOUT=64, CNT_W=4).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pcie_link_monitor;

  localparam int P_SYNC   = 2;
  localparam int P_STABLE = 16;
  localparam int P_TMO    = 64;
  localparam int P_CNT_W  = 4;

  localparam logic [1:0] c_down  = 2'd0;
  localparam logic [1:0] c_train = 2'd1;
  localparam logic [1:0] c_qual  = 2'd2;
  localparam logic [1:0] c_up    = 2'd3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               linkup_in;
  logic               dlup_in;
  logic               serr_in;
  logic               surprise_down_in;
  logic               clear_stats;
  logic               irq_ack;
  logic [1:0]         link_state;
  logic               link_up;
  logic [P_CNT_W-1:0] linkup_cnt;
  logic [P_CNT_W-1:0] surprise_down_cnt;
  logic [P_CNT_W-1:0] serr_cnt;
  logic               train_timeout;
  logic               irq;
  logic [2:0]         irq_cause;
`ifdef PCIE_LINK_MON_TIMESTAMP_EN
  logic [31:0]        last_up_ts;
  int                 tb_cyc;
  int                 ts_expect;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcie_link_monitor #(
    .SYNC_STAGES   (P_SYNC),
    .STABLE_CYCLES (P_STABLE),
    .TRAIN_TIMEOUT (P_TMO),
    .CNT_W         (P_CNT_W)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .linkup_in         (linkup_in),
    .dlup_in           (dlup_in),
    .serr_in           (serr_in),
    .surprise_down_in  (surprise_down_in),
    .clear_stats       (clear_stats),
    .irq_ack           (irq_ack),
    .link_state        (link_state),
    .link_up           (link_up),
    .linkup_cnt        (linkup_cnt),
    .surprise_down_cnt (surprise_down_cnt),
    .serr_cnt          (serr_cnt),
    .train_timeout     (train_timeout),
    .irq               (irq),
`ifdef PCIE_LINK_MON_TIMESTAMP_EN
    .last_up_ts        (last_up_ts),
`endif
    .irq_cause         (irq_cause)
  );

`ifdef PCIE_LINK_MON_TIMESTAMP_EN
  // Bench-side count of clock edges since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    linkup_in        = 1'b0;
    dlup_in          = 1'b0;
    serr_in          = 1'b0;
    surprise_down_in = 1'b0;
    clear_stats      = 1'b0;
    irq_ack          = 1'b0;
    tick(3);

    // Reset values
    chk("rst_state",   32'(link_state), 32'(c_down));
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_lu_cnt",  32'(linkup_cnt), 32'd0);
    chk("rst_sd_cnt",  32'(surprise_down_cnt), 32'd0);
    chk("rst_se_cnt",  32'(serr_cnt), 32'd0);
    chk("rst_tmo",     32'(train_timeout), 32'd0);
    chk("rst_irq",     32'(irq), 32'd0);
    chk("rst_cause",   32'(irq_cause), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Normal link-up: linkup, then dlup 10 cycles later
    linkup_in = 1'b1;
    tick(2); chk("t1_still_down", 32'(link_state), 32'(c_down));
    tick(1); chk("t1_train", 32'(link_state), 32'(c_train));
    tick(7);
    dlup_in = 1'b1;
    tick(2); chk("t1_train2", 32'(link_state), 32'(c_train));
    tick(1); chk("t1_qual", 32'(link_state), 32'(c_qual));
    tick(15);
    chk("t1_qual15", 32'(link_state), 32'(c_qual));
    chk("t1_lu_low", 32'(link_up), 32'd0);
    tick(1);
    chk("t1_up", 32'(link_state), 32'(c_up));
    chk("t1_lu_high", 32'(link_up), 32'd1);
    chk("t1_lu_cnt", 32'(linkup_cnt), 32'd1);
    chk("t1_irq", 32'(irq), 32'd0);
`ifdef PCIE_LINK_MON_TIMESTAMP_EN
    ts_expect = tb_cyc - 1;
    chk("t1_ts", last_up_ts, 32'(ts_expect));
`endif

    // Link loss and acknowledge
    linkup_in = 1'b0;
    tick(2); chk("t3_still_up", 32'(link_up), 32'd1);
    tick(1);
    chk("t3_down", 32'(link_state), 32'(c_down));
    chk("t3_lu_fall", 32'(link_up), 32'd0);
    chk("t3_cause", 32'(irq_cause), 32'b001);
    chk("t3_irq", 32'(irq), 32'd1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("t3_ack_irq", 32'(irq), 32'd0);
    chk("t3_ack_cause", 32'(irq_cause), 32'd0);

    // Glitch during qualification (dlup still high)
    linkup_in = 1'b1;
    tick(3); chk("t2_train", 32'(link_state), 32'(c_train));
    tick(1); chk("t2_qual", 32'(link_state), 32'(c_qual));
    tick(8);
    dlup_in = 1'b0;
    tick(3);
    chk("t2_back_train", 32'(link_state), 32'(c_train));
    chk("t2_lu_low", 32'(link_up), 32'd0);
    dlup_in = 1'b1;
    tick(2); chk("t2_train_hold", 32'(link_state), 32'(c_train));
    tick(1);
    chk("t2_requal", 32'(link_state), 32'(c_qual));
    chk("t2_cnt_same", 32'(linkup_cnt), 32'd1);
    tick(15);
    chk("t2_qual15", 32'(link_state), 32'(c_qual));
    chk("t2_cnt_same2", 32'(linkup_cnt), 32'd1);
    tick(1);
    chk("t2_up", 32'(link_state), 32'(c_up));
    chk("t2_lu_cnt", 32'(linkup_cnt), 32'd2);

    // Link loss again, serr edge lands on the ack cycle
    linkup_in = 1'b0;
    tick(3);
    chk("t3b_down", 32'(link_state), 32'(c_down));
    chk("t3b_cause", 32'(irq_cause), 32'b001);
    serr_in = 1'b1;
    tick(2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    serr_in = 1'b0;
    chk("t3b_cause_race", 32'(irq_cause), 32'b010);
    chk("t3b_irq", 32'(irq), 32'd1);
    chk("t3b_serr_cnt", 32'(serr_cnt), 32'd1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    chk("t3b_clear", 32'(irq_cause), 32'd0);

    // Training timeout: linkup high, dlup low
    dlup_in   = 1'b0;
    linkup_in = 1'b1;
    tick(3); chk("t4_train", 32'(link_state), 32'(c_train));
    tick(63); chk("t4_tmo_low", 32'(train_timeout), 32'd0);
    tick(1);
    chk("t4_tmo", 32'(train_timeout), 32'd1);
    chk("t4_cause", 32'(irq_cause), 32'b100);
    chk("t4_irq", 32'(irq), 32'd1);
    chk("t4_stay", 32'(link_state), 32'(c_train));
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    chk("t4_clr_tmo", 32'(train_timeout), 32'd0);
    chk("t4_clr_cause", 32'(irq_cause), 32'b100);
    chk("t4_clr_lu", 32'(linkup_cnt), 32'd0);
    chk("t4_clr_serr", 32'(serr_cnt), 32'd0);
    tick(5);
    chk("t4_once", 32'(train_timeout), 32'd0);

    // Saturation: 20 serr pulses on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      serr_in = 1'b1; tick(2);
      serr_in = 1'b0; tick(2);
    end
    tick(3);
    chk("t5_serr_sat", 32'(serr_cnt), 32'd15);
    chk("t5_cause", 32'(irq_cause), 32'b110);

    // Surprise-down count, then clear racing an edge
    surprise_down_in = 1'b1; tick(4);
    surprise_down_in = 1'b0; tick(3);
    chk("t5_sd_one", 32'(surprise_down_cnt), 32'd1);
    surprise_down_in = 1'b1;
    tick(2);
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    chk("t5_sd_race", 32'(surprise_down_cnt), 32'd0);
    chk("t5_serr_clr", 32'(serr_cnt), 32'd0);
    tick(2);
    chk("t5_sd_stay0", 32'(surprise_down_cnt), 32'd0);
    surprise_down_in = 1'b0;

    // Asynchronous reset in the middle of qualification
    dlup_in = 1'b1;
    tick(3); chk("t6_qual", 32'(link_state), 32'(c_qual));
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("t6_state", 32'(link_state), 32'(c_down));
    chk("t6_link_up", 32'(link_up), 32'd0);
    chk("t6_cause", 32'(irq_cause), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_tmo", 32'(train_timeout), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(2); chk("t6_sync_clr", 32'(link_state), 32'(c_down));
    tick(1); chk("t6_retrain", 32'(link_state), 32'(c_train));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_pcie_link_monitor

`default_nettype wire
